// File: rtl/arm_defines.sv
// Shared ARM pipeline definitions.
//   ADDR_WIDTH / INSTR_WIDTH : default address and instruction widths
//   PC_INCR                  : sequential PC step (one 32-bit instruction)
//   NOP_INSTR                : bubble encoding used by downstream stages
//   fetch_entry_t            : {instruction, pc} pair handed from fetch to decode
package arm_defines;

  localparam int unsigned ADDR_WIDTH  = 32;
  localparam int unsigned INSTR_WIDTH = 32;

  localparam logic [ADDR_WIDTH-1:0]  PC_INCR   = 32'd4;
  localparam logic [INSTR_WIDTH-1:0] NOP_INSTR = 32'hE000_0000;

  typedef struct packed {
    logic [INSTR_WIDTH-1:0] instruction;
    logic [ADDR_WIDTH-1:0]  pc;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Synchronous ring-buffer FIFO with flush, used between fetch and decode.
//   clk, rst   : clock, synchronous active-high reset
//   flush_i    : drop all contents (pointers and count back to zero)
//   push_i     : enqueue data_i (ignored when full unless popping in the same cycle)
//   pop_i      : dequeue head (ignored when empty)
//   data_o     : head entry, read from storage registers
//   full_o, empty_o, count_o : occupancy status
// Depth must be a power of two so the pointers wrap naturally.
module fetch_queue #(
  parameter int unsigned Depth = 2,
  parameter int unsigned Width = 64
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush_i,
  input  logic                         push_i,
  input  logic                         pop_i,
  input  logic [Width-1:0]             data_i,
  output logic [Width-1:0]             data_o,
  output logic                         full_o,
  output logic                         empty_o,
  output logic [$clog2(Depth+1)-1:0]   count_o
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CntW = $clog2(Depth + 1);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]  count_q, count_d;
  logic             push_ok, pop_ok;

  assign full_o  = (count_q == CntW'(Depth));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign data_o  = mem_q[rd_ptr_q];

  // A full queue may still accept a push when the head leaves in the same cycle.
  assign push_ok = push_i & (~full_o | pop_i);
  assign pop_ok  = pop_i & ~empty_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_ok) wr_ptr_d = wr_ptr_q + PtrW'(1);
      if (pop_ok)  rd_ptr_d = rd_ptr_q + PtrW'(1);
      unique case ({push_ok, pop_ok})
        2'b10:   count_d = count_q + CntW'(1);
        2'b01:   count_d = count_q - CntW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset; count gates every read.
  always_ff @(posedge clk) begin
    if (!rst && !flush_i && push_ok) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, drives the combinational instruction
// memory and buffers {instruction, PC+4} pairs for decode.
//   clk, rst                        : clock, synchronous active-high reset
//   imem_address / imem_instruction : instruction memory port (same-cycle read)
//   branch_taken / branch_address   : redirect from execute; flushes the queue
//   id_valid / id_ready             : handshake towards decode
//   id_instruction / id_pc          : head entry, zero while id_valid is low
module fetch_stage
  import arm_defines::*;
#(
  parameter int unsigned           ADDR_WIDTH  = arm_defines::ADDR_WIDTH,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC    = '0,
  parameter int unsigned           QUEUE_DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  output logic [ADDR_WIDTH-1:0]  imem_address,
  input  logic [INSTR_WIDTH-1:0] imem_instruction,
  input  logic                   branch_taken,
  input  logic [ADDR_WIDTH-1:0]  branch_address,
  input  logic                   id_ready,
  output logic                   id_valid,
  output logic [INSTR_WIDTH-1:0] id_instruction,
  output logic [ADDR_WIDTH-1:0]  id_pc
);

  localparam int unsigned EntryW = INSTR_WIDTH + ADDR_WIDTH;
  localparam int unsigned CntW   = $clog2(QUEUE_DEPTH + 1);

  logic [ADDR_WIDTH-1:0] pc_q, pc_d, pc_plus4;
  logic                  pop, fetch, push;
  logic [EntryW-1:0]     q_head;
  logic                  q_full, q_empty;
  logic [CntW-1:0]       q_count;

  assign imem_address = pc_q;
  assign pc_plus4     = pc_q + ADDR_WIDTH'(PC_INCR);

  assign id_valid = ~q_empty;
  assign pop      = id_valid & id_ready;
  // Back-pressure uses the same-cycle pop so a full queue being drained keeps fetching.
  assign fetch    = ~q_full | pop;
  assign push     = fetch & ~branch_taken;

  always_comb begin
    pc_d = pc_q;
    if (branch_taken) begin
      pc_d = {branch_address[ADDR_WIDTH-1:2], 2'b00};
    end else if (fetch) begin
      pc_d = pc_plus4;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  fetch_queue #(
    .Depth (QUEUE_DEPTH),
    .Width (EntryW)
  ) u_fetch_queue (
    .clk     (clk),
    .rst     (rst),
    .flush_i (branch_taken),
    .push_i  (push),
    .pop_i   (pop),
    .data_i  ({imem_instruction, pc_plus4}),
    .data_o  (q_head),
    .full_o  (q_full),
    .empty_o (q_empty),
    .count_o (q_count)
  );

  assign id_instruction = id_valid ? q_head[EntryW-1 -: INSTR_WIDTH] : '0;
  assign id_pc          = id_valid ? q_head[ADDR_WIDTH-1:0] : '0;

  occupancy_bounded: assert property (@(posedge clk) disable iff (rst)
    q_count <= CntW'(QUEUE_DEPTH));

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;
  import arm_defines::*;

  localparam logic [31:0] RST_PC = 32'hFFFF_FFF0;
  localparam int          DEPTH  = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] imem_address;
  logic [31:0] imem_instruction;
  logic        branch_taken;
  logic [31:0] branch_address;
  logic        id_ready;
  logic        id_valid;
  logic [31:0] id_instruction;
  logic [31:0] id_pc;

  fetch_stage #(
    .ADDR_WIDTH  (32),
    .RESET_PC    (RST_PC),
    .QUEUE_DEPTH (DEPTH)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .imem_address     (imem_address),
    .imem_instruction (imem_instruction),
    .branch_taken     (branch_taken),
    .branch_address   (branch_address),
    .id_ready         (id_ready),
    .id_valid         (id_valid),
    .id_instruction   (id_instruction),
    .id_pc            (id_pc)
  );

  always #5 clk = ~clk;

  // Program image: a bijective scramble of the address, so every word is distinct.
  function automatic logic [31:0] prog(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  assign imem_instruction = prog(imem_address);

  // Reference model: expected decode-side FIFO contents and the PC.
  fetch_entry_t exp_q[$];
  logic [31:0]  m_pc;
  bit           m_live = 0;
  int           checks = 0;
  int           errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Monitor: compares presented outputs and consumes the expected head on handshake.
  always @(negedge clk) begin
    if (m_live) begin
      chk("imem_address", {32'd0, imem_address}, {32'd0, m_pc});
      chk("id_valid", {63'd0, id_valid}, {63'd0, exp_q.size() > 0});
      if (exp_q.size() > 0) begin
        chk("id_instruction", {32'd0, id_instruction}, {32'd0, exp_q[0].instruction});
        chk("id_pc", {32'd0, id_pc}, {32'd0, exp_q[0].pc});
        if (id_ready) void'(exp_q.pop_front());
      end else begin
        chk("id_instruction_idle", {32'd0, id_instruction}, 64'd0);
        chk("id_pc_idle", {32'd0, id_pc}, 64'd0);
      end
    end
  end

  // Applies inputs for one clock edge and advances the model across that edge.
  task automatic drive(input bit r, input bit b, input logic [31:0] a, input bit rd);
    bit fetch;
    rst            = r;
    branch_taken   = b;
    branch_address = a;
    id_ready       = rd;
    // Decided from occupancy before the monitor consumes this cycle's head.
    fetch = (exp_q.size() < DEPTH) || (exp_q.size() > 0 && rd);
    @(posedge clk);
    if (r) begin
      exp_q.delete();
      m_pc   = RST_PC;
      m_live = 1;
    end else if (m_live) begin
      if (b) begin
        exp_q.delete();
        m_pc = {a[31:2], 2'b00};
      end else if (fetch) begin
        exp_q.push_back('{instruction: prog(m_pc), pc: m_pc + 32'd4});
        m_pc = m_pc + 32'd4;
      end
    end
    #1;
  endtask

  task automatic idle(input int n, input bit rd);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 32'd0, rd);
  endtask

  initial begin
    rst = 1'b1; branch_taken = 1'b0; branch_address = '0; id_ready = 1'b0;
    #1;
    drive(1'b1, 1'b0, 32'd0, 1'b1);
    drive(1'b1, 1'b0, 32'd0, 1'b1);

    // Streaming with decode always ready; crosses the 2^32 wrap.
    idle(10, 1'b1);

    // Back-pressure from reset, then drain.
    drive(1'b1, 1'b0, 32'd0, 1'b0);
    idle(5, 1'b0);
    idle(5, 1'b1);

    // Branch with a full queue.
    idle(3, 1'b0);
    drive(1'b0, 1'b1, 32'h94, 1'b0);
    idle(4, 1'b1);

    // Misaligned target, branch coinciding with a pop.
    idle(2, 1'b0);
    drive(1'b0, 1'b1, 32'h96, 1'b1);
    idle(3, 1'b1);

    // Reset wins over a simultaneous branch.
    idle(3, 1'b0);
    drive(1'b1, 1'b1, 32'h200, 1'b0);
    idle(3, 1'b1);

    // Randomised traffic.
    for (int i = 0; i < 600; i++) begin
      bit          r, b, rd;
      logic [31:0] a;
      r  = ($urandom_range(0, 59) == 0);
      b  = ($urandom_range(0, 7) == 0);
      rd = ($urandom_range(0, 2) != 0);
      a  = $urandom;
      if ($urandom_range(0, 3) == 0) a = 32'hFFFF_FFF0 | (a & 32'hF);
      drive(r, b, a, rd);
    end
    idle(4, 1'b1);

    @(negedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
